// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared SHA-256 definitions used by the block padder and the compression
//   core: block geometry, the padding marker word, the padder state encoding
//   and helpers for block accounting and padding-word selection.
package sha256_pkg;

  localparam int          SHA256_BLOCK_WORDS = 16;
  localparam logic [31:0] SHA256_PAD_WORD    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUILD   = 2'd1,
    PRESENT = 2'd2
  } pad_state_t;

  // Number of 512-bit blocks for a word-aligned message of num_words words:
  // message + one marker word + two length words, rounded up to 16 words.
  // Worst case (65535 words) gives 4097 blocks, which fits in 13 bits.
  function automatic logic [12:0] sha256_num_blocks(input logic [15:0] num_words);
    return 13'((17'(num_words) + 17'd18) >> 4);
  endfunction

  // Value of a slot that does not come from memory. g is the global word
  // index (block_idx*16 + k), w the message length in words, last flags the
  // final block and k is the slot inside the block.
  function automatic logic [31:0] sha256_fill_word(
    input logic [16:0] g,
    input logic [15:0] w,
    input logic        last,
    input logic [3:0]  k
  );
    if (g == {1'b0, w})
      return SHA256_PAD_WORD;
    else if (last && (k == 4'd15))
      return {11'd0, w, 5'd0};  // bit length w*32; upper length word is 0
    else
      return 32'h0;
  endfunction

endpackage

// File: rtl/sha256_block_padder.sv
// sha256_block_padder
//   Reads a word-aligned message from a 1-cycle-latency memory, applies
//   SHA-256 padding (marker word, zero fill, 64-bit bit length) and hands
//   out 512-bit blocks over a valid/ready handshake.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   start             one-cycle request, sampled only in IDLE
//   message_addr      word address of message word 0 (latched on start)
//   num_words         message length in 32-bit words (latched on start)
//   busy              high from the cycle after start until the last transfer
//   done              one-cycle pulse after the last block transfer
//   mem_addr, mem_re  memory read request; data returns one cycle later
//   mem_read_data     memory read data
//   block_data        padded block, word 0 in [511:480], word 15 in [31:0]
//   block_valid       block available (PRESENT state)
//   block_ready       consumer accepts the block
//   block_last        final block of the message, qualifies block_valid
//   block_idx         index of the current block
module sha256_block_padder
  import sha256_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [15:0]       num_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_read_data,
  output logic [511:0]      block_data,
  output logic              block_valid,
  input  logic              block_ready,
  output logic              block_last,
  output logic [12:0]       block_idx
);

  pad_state_t r_state, w_next_state;

  logic [ADDR_W-1:0] r_base;
  logic [15:0]       r_nw;
  logic [12:0]       r_nb;
  logic [12:0]       r_idx;
  // Slot counter: 0..15 handle slots, 16 is the drain cycle.
  logic [4:0]        r_k;
  // Slot k lives in r_blk[15-k] so the packed vector maps straight onto
  // block_data with word 0 in the top bits.
  logic [15:0][31:0] r_blk;
  // A read issued last cycle whose data must land in r_pend_slot now.
  logic              r_pend;
  logic [3:0]        r_pend_slot;
  logic              r_done;

  logic [16:0]       w_g;
  logic              w_last;
  logic              w_slot_cyc;
  logic              w_from_mem;
  logic              w_xfer;

  // Global word index is block_idx*16 + k, i.e. a plain concatenation.
  assign w_g        = {r_idx, r_k[3:0]};
  assign w_last     = (r_idx == (r_nb - 13'd1));
  assign w_slot_cyc = (r_state == BUILD) && !r_k[4];
  assign w_from_mem = w_slot_cyc && (w_g < {1'b0, r_nw});

  // Read request is decoded from state so it drops as soon as reset hits.
  assign mem_re   = w_from_mem;
  assign mem_addr = w_from_mem ? (r_base + ADDR_W'(w_g)) : '0;

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign block_valid = (r_state == PRESENT);
  assign block_last  = block_valid && w_last;
  assign block_idx   = r_idx;
  assign block_data  = r_blk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_xfer       = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next_state = BUILD;
      BUILD:   if (r_k[4]) w_next_state = PRESENT;
      PRESENT: begin
        if (block_ready) begin
          w_xfer       = 1'b1;
          w_next_state = w_last ? IDLE : BUILD;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base      <= '0;
      r_nw        <= '0;
      r_nb        <= '0;
      r_idx       <= '0;
      r_k         <= '0;
      r_blk       <= '0;
      r_pend      <= 1'b0;
      r_pend_slot <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_pend <= 1'b0;

      // Capture data for the read issued in the previous cycle; this is
      // always a different slot from the one handled this cycle.
      if (r_pend) r_blk[~r_pend_slot] <= mem_read_data;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_base <= message_addr;
            r_nw   <= num_words;
            r_nb   <= sha256_num_blocks(num_words);
            r_idx  <= '0;
            r_k    <= '0;
          end
        end
        BUILD: begin
          if (!r_k[4]) begin
            if (w_from_mem) begin
              r_pend      <= 1'b1;
              r_pend_slot <= r_k[3:0];
            end else begin
              r_blk[~r_k[3:0]] <= sha256_fill_word(w_g, r_nw, w_last, r_k[3:0]);
            end
            r_k <= r_k + 5'd1;
          end
        end
        PRESENT: begin
          if (w_xfer) begin
            if (w_last) begin
              r_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 13'd1;
              r_k   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_padder.sv
// tb_sha256_block_padder
//   Directed bench for sha256_block_padder: a small memory model answers
//   reads one cycle later, a negedge monitor logs reads and done pulses, and
//   each scenario task compares the presented blocks with hand-built vectors.
module tb_sha256_block_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  message_addr;
  logic [15:0]  num_words;
  logic         busy;
  logic         done;
  logic [15:0]  mem_addr;
  logic         mem_re;
  logic [31:0]  mem_read_data = 32'h0;
  logic [511:0] block_data;
  logic         block_valid;
  logic         block_ready;
  logic         block_last;
  logic [12:0]  block_idx;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] tmem [0:255];
  int          rd_cnt   = 0;
  int          done_cnt = 0;
  logic [15:0] rd_q[$];

  sha256_block_padder #(.ADDR_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .message_addr (message_addr),
    .num_words    (num_words),
    .busy         (busy),
    .done         (done),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_read_data(mem_read_data),
    .block_data   (block_data),
    .block_valid  (block_valid),
    .block_ready  (block_ready),
    .block_last   (block_last),
    .block_idx    (block_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_read_data <= mem_re ? tmem[mem_addr[7:0]] : 32'h0;

  always @(negedge clk) begin
    if (mem_re) begin
      rd_cnt++;
      rd_q.push_back(mem_addr);
    end
    if (done) done_cnt++;
  end

  // Called at a negedge; leaves the bench at the negedge after the start edge.
  task automatic do_start(input logic [15:0] base, input logic [15:0] w);
    message_addr = base;
    num_words    = w;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  // Bounded wait for block_valid; n counts negedges waited.
  task automatic wait_valid(input string name, output int n);
    bit ok = 0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (block_valid) begin ok = 1; break; end
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (!ok) $display("FAIL %s_timeout: block_valid not seen after %0d cycles, required within 60", name, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({busy, done, mem_re, mem_addr, block_valid, block_last, block_idx, block_data} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b re=%b addr=%h v=%b last=%b idx=%0d data=%h, required all 0",
               busy, done, mem_re, mem_addr, block_valid, block_last, block_idx, block_data);
    else n_pass++;
  endtask

  task automatic test_w1();
    int rd0, q0, dn0, lat;
    logic [511:0] exp;
    exp = '0;
    exp[511:480] = 32'h61626364;
    exp[479:448] = 32'h80000000;
    exp[31:0]    = 32'h00000020;
    block_ready = 1'b1;
    rd0 = rd_cnt; q0 = rd_q.size(); dn0 = done_cnt;
    do_start(16'h0010, 16'd1);
    wait_valid("w1", lat);
    n_chk++; if (lat !== 17) $display("FAIL w1_latency: valid %0d cycles after start, required 18", lat + 1); else n_pass++;
    n_chk++; if (block_data !== exp) $display("FAIL w1_data: got %h required %h", block_data, exp); else n_pass++;
    n_chk++; if (block_last !== 1'b1 || block_idx !== 13'd0) $display("FAIL w1_last_idx: last=%b idx=%0d required 1/0", block_last, block_idx); else n_pass++;
    n_chk++; if (rd_cnt - rd0 !== 1 || rd_q[q0] !== 16'h0010) $display("FAIL w1_reads: count=%0d addr=%h required 1 @0010", rd_cnt - rd0, rd_q[q0]); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b1 || busy !== 1'b0 || block_valid !== 1'b0) $display("FAIL w1_done: done=%b busy=%b valid=%b required 1/0/0", done, busy, block_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b0 || done_cnt - dn0 !== 1) $display("FAIL w1_done_pulse: done=%b pulses=%0d required 0/1", done, done_cnt - dn0); else n_pass++;
  endtask

  task automatic test_w20();
    int rd0, q0, gap;
    bit seq_ok;
    logic [511:0] exp0, exp1;
    exp0 = '0; exp1 = '0;
    for (int k = 0; k < 16; k++) exp0[511-32*k -: 32] = 32'(k);
    for (int k = 0; k < 4; k++)  exp1[511-32*k -: 32] = 32'(16 + k);
    exp1[383:352] = 32'h80000000;
    exp1[31:0]    = 32'h00000280;
    block_ready = 1'b1;
    rd0 = rd_cnt; q0 = rd_q.size();
    do_start(16'h0040, 16'd20);
    wait_valid("w20_b0", gap);
    n_chk++; if (block_data !== exp0) $display("FAIL w20_b0_data: got %h required %h", block_data, exp0); else n_pass++;
    n_chk++; if (block_last !== 1'b0 || block_idx !== 13'd0) $display("FAIL w20_b0_last_idx: last=%b idx=%0d required 0/0", block_last, block_idx); else n_pass++;
    @(negedge clk);
    wait_valid("w20_b1", gap);
    n_chk++; if (gap !== 17) $display("FAIL w20_gap: valid %0d cycles after transfer, required 18", gap + 1); else n_pass++;
    n_chk++; if (block_data !== exp1) $display("FAIL w20_b1_data: got %h required %h", block_data, exp1); else n_pass++;
    n_chk++; if (block_last !== 1'b1 || block_idx !== 13'd1) $display("FAIL w20_b1_last_idx: last=%b idx=%0d required 1/1", block_last, block_idx); else n_pass++;
    seq_ok = (rd_cnt - rd0 == 20);
    if (seq_ok) for (int i = 0; i < 20; i++) if (rd_q[q0+i] !== 16'(16'h0040 + i)) seq_ok = 0;
    n_chk++; if (!seq_ok) $display("FAIL w20_reads: count=%0d required 20 sequential from 0040", rd_cnt - rd0); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b1) $display("FAIL w20_done: done=%b required 1", done); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_w14();
    int rd0, n;
    logic [511:0] exp0, exp1;
    exp0 = '0; exp1 = '0;
    for (int k = 0; k < 14; k++) exp0[511-32*k -: 32] = 32'(k);
    exp0[63:32] = 32'h80000000;
    exp1[31:0]  = 32'h000001C0;
    block_ready = 1'b1;
    rd0 = rd_cnt;
    do_start(16'h0040, 16'd14);
    wait_valid("w14_b0", n);
    n_chk++; if (block_data !== exp0 || block_last !== 1'b0) $display("FAIL w14_b0: last=%b data=%h required 0 %h", block_last, block_data, exp0); else n_pass++;
    @(negedge clk);
    wait_valid("w14_b1", n);
    n_chk++; if (block_data !== exp1 || block_last !== 1'b1 || block_idx !== 13'd1) $display("FAIL w14_b1: last=%b idx=%0d data=%h required 1 1 %h", block_last, block_idx, block_data, exp1); else n_pass++;
    n_chk++; if (rd_cnt - rd0 !== 14) $display("FAIL w14_reads: count=%0d required 14", rd_cnt - rd0); else n_pass++;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_w0();
    int rd0, n;
    logic [511:0] exp;
    exp = '0;
    exp[511:480] = 32'h80000000;
    block_ready = 1'b1;
    rd0 = rd_cnt;
    do_start(16'h0040, 16'd0);
    wait_valid("w0", n);
    n_chk++; if (block_data !== exp || block_last !== 1'b1) $display("FAIL w0_block: last=%b data=%h required 1 %h", block_last, block_data, exp); else n_pass++;
    n_chk++; if (rd_cnt - rd0 !== 0) $display("FAIL w0_reads: count=%0d required 0", rd_cnt - rd0); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b1) $display("FAIL w0_done: done=%b required 1", done); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int rd0, n;
    bit stable;
    logic [511:0] d0, exp1;
    logic l0;
    logic [12:0] i0;
    exp1 = '0;
    for (int k = 0; k < 4; k++) exp1[511-32*k -: 32] = 32'(16 + k);
    exp1[383:352] = 32'h80000000;
    exp1[31:0]    = 32'h00000280;
    block_ready = 1'b0;
    rd0 = rd_cnt;
    do_start(16'h0040, 16'd20);
    repeat (4) @(negedge clk);
    do_start(16'h0010, 16'd1);  // ignored: busy
    wait_valid("bp_b0", n);
    d0 = block_data; l0 = block_last; i0 = block_idx;
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (block_valid !== 1'b1 || block_data !== d0 || block_last !== l0 || block_idx !== i0) stable = 0;
      start = (i == 1);
      message_addr = 16'h0010; num_words = 16'd1;
    end
    start = 1'b0;
    n_chk++; if (!stable || i0 !== 13'd0 || l0 !== 1'b0) $display("FAIL bp_stall_stable: stable=%b idx=%0d last=%b required 1/0/0", stable, i0, l0); else n_pass++;
    block_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (block_valid !== 1'b0 || block_idx !== 13'd1) $display("FAIL bp_advance: valid=%b idx=%0d required 0/1", block_valid, block_idx); else n_pass++;
    wait_valid("bp_b1", n);
    n_chk++; if (block_data !== exp1 || block_last !== 1'b1) $display("FAIL bp_b1: last=%b data=%h required 1 %h", block_last, block_data, exp1); else n_pass++;
    repeat (25) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || rd_cnt - rd0 !== 20) $display("FAIL bp_ignored_start: busy=%b reads=%0d required 0/20", busy, rd_cnt - rd0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dn0, n;
    logic [511:0] exp0;
    exp0 = '0;
    for (int k = 0; k < 16; k++) exp0[511-32*k -: 32] = 32'(k);
    block_ready = 1'b1;
    dn0 = done_cnt;
    do_start(16'h0040, 16'd20);
    wait_valid("rm_b0", n);
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (mem_re !== 1'b1 || block_idx !== 13'd1) $display("FAIL rm_pre: mem_re=%b idx=%0d required 1/1", mem_re, block_idx); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, mem_re, mem_addr, block_valid, block_last, block_idx, block_data} !== '0)
      $display("FAIL rm_outputs: busy=%b done=%b re=%b addr=%h v=%b idx=%0d data=%h, required all 0",
               busy, done, mem_re, mem_addr, block_valid, block_idx, block_data);
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (done_cnt !== dn0 || busy !== 1'b0) $display("FAIL rm_no_done: pulses=%0d busy=%b required 0/0", done_cnt - dn0, busy); else n_pass++;
    do_start(16'h0040, 16'd20);
    wait_valid("rm_restart", n);
    n_chk++; if (block_data !== exp0 || block_idx !== 13'd0 || block_last !== 1'b0) $display("FAIL rm_restart: idx=%0d last=%b data=%h required 0 0 %h", block_idx, block_last, block_data, exp0); else n_pass++;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_wrap();
    int q0, n;
    logic [511:0] exp;
    exp = '0;
    exp[511:480] = 32'hA5A50001;
    exp[479:448] = 32'hA5A50002;
    exp[447:416] = 32'hA5A50003;
    exp[415:384] = 32'h80000000;
    exp[31:0]    = 32'h00000060;
    block_ready = 1'b1;
    q0 = rd_q.size();
    do_start(16'hFFFE, 16'd3);
    wait_valid("wrap", n);
    n_chk++; if (block_data !== exp) $display("FAIL wrap_data: got %h required %h", block_data, exp); else n_pass++;
    n_chk++;
    if (rd_q.size() - q0 !== 3 || rd_q[q0] !== 16'hFFFE || rd_q[q0+1] !== 16'hFFFF || rd_q[q0+2] !== 16'h0000)
      $display("FAIL wrap_addr: count=%0d required 3 reads FFFE FFFF 0000", rd_q.size() - q0);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; message_addr = '0; num_words = '0; block_ready = 1'b0;
    for (int i = 0; i < 256; i++) tmem[i] = 32'hDEAD0000 | 32'(i);
    for (int i = 0; i < 20; i++)  tmem[8'h40 + i] = 32'(i);
    tmem[8'h10] = 32'h61626364;
    tmem[8'hFE] = 32'hA5A50001;
    tmem[8'hFF] = 32'hA5A50002;
    tmem[8'h00] = 32'hA5A50003;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_w1();
    test_w20();
    test_w14();
    test_w0();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sha256_block_padder.md
# sha256_block_padder

Upstream feeder for the SHA-256 compression core. On `start` it reads a word-aligned message of `num_words` 32-bit words from memory, applies SHA-256 padding (0x80 marker word, zero fill, 64-bit big-endian bit length) and delivers a sequence of 512-bit blocks over a valid/ready handshake. The compression core consumes the blocks directly and needs no knowledge of message length or padding.

## Interface
- `ADDR_W`, default 16: memory word-address width.
- `clk`  in  1  sole clock; memory is clocked on the same clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `message_addr`  in  ADDR_W  word address of message word 0. Latched on accepted `start`.
- `num_words`  in  16  message length in words, 0..65535. Latched on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the last block transfers.
- `done`  out  1  one-cycle pulse in the cycle after the last block transfer.
- `mem_addr`  out  ADDR_W  read address.
- `mem_re`  out  1  read strobe. Data returns on `mem_read_data` exactly 1 cycle later.
- `mem_read_data`  in  32  read data.
- `block_data`  out  512  padded block. Word 0 occupies [511:480], word 15 occupies [31:0].
- `block_valid`  out  1  block available.
- `block_ready`  in  1  consumer accepts the block.
- `block_last`  out  1  qualifies `block_valid`: this is the final block.
- `block_idx`  out  13  index of the current block, starting at 0.

## Operation
- Total block count: `nb = floor((num_words + 18) / 16)`. Examples: w=0 → 1, w=13 → 1, w=14 → 2, w=20 → 2.
- Each output word is at global index `g = block_idx*16 + k`, with `k` = 0..15. Its source is chosen by the first matching rule:
  - `g < w`: memory word at `message_addr + g`.
  - `g == w`: 32'h80000000.
  - last block and `k == 14`: 32'h0 (upper half of the length, always zero).
  - last block and `k == 15`: `w*32` (zero-extended; w*32 ≤ 2,097,120 fits in 32 bits).
  - otherwise: 0.
- States: IDLE, BUILD, PRESENT.
- IDLE → BUILD on `start`. In the same transition: `block_idx` clears, the `start` inputs are latched, and `k` clears.
- BUILD runs a fixed 17 cycles per block, independent of how many slots come from memory:
  - Cycles 0..15 handle slot `k`. A memory slot drives `mem_re=1` and `mem_addr = message_addr + g`; the returned data is written into slot `k` in the following cycle. A non-memory slot is written directly with `mem_re=0`.
  - Cycle 16 is the drain cycle. It captures the slot-15 read. The state then moves to PRESENT.
- PRESENT:
  - `block_valid=1`. `block_last = (block_idx == nb-1)`.
  - `block_data`, `block_last` and `block_idx` are held stable while `block_valid && !block_ready`.
  - On transfer of a non-last block: `block_idx` increments and the state returns to BUILD with `k=0`.
  - On transfer of the last block: the state goes to IDLE and `done` pulses.
- Address arithmetic wraps modulo 2^ADDR_W.
- `start` is ignored while `busy` is high.
- `block_ready` is ignored outside PRESENT.

## Timing
- Reset values: all outputs are 0, and the internal block register is 0. State is IDLE.
- Reset asserted mid-operation aborts immediately. No `done` pulse, no partial block is presented, and `mem_re` drops asynchronously.
- Latency from `start` to the first `block_valid` is 18 cycles: 1 cycle to enter BUILD, then 17 BUILD cycles.
- Block-to-block: `block_valid` for the next block rises 18 cycles after the previous transfer cycle.
- `block_ready` may be held high permanently. The core still observes exactly one transfer per block.
- `block_valid` never depends combinationally on `block_ready`.

## Structure
Shared package `sha256_pkg` holds:
- `SHA256_BLOCK_WORDS = 16`.
- `SHA256_PAD_WORD = 32'h80000000`.
- The padder state enum typedef.
- Function `sha256_num_blocks(num_words)`, shared with the compression core's block accounting.

The block is a single module with no sub-module. Word selection is a package function or a local combinational mux.

## Test plan
- w=1, word 0x61626364 at address 0x0010, `block_ready` tied high:
  - exactly 1 `mem_re`, at address 0x0010;
  - block = 61626364, 80000000, zeros, word 15 = 00000020;
  - `block_last=1`; `done` one cycle after the transfer.
- w=20, words 0..19 = index value:
  - 2 blocks, 20 reads;
  - block 1 = words 16..19, 80000000, zeros, word 15 = 00000280;
  - block 0 `block_last=0`, block 1 `block_last=1`.
- w=14:
  - 2 blocks; block 0 = words 0..13, 80000000, 0;
  - block 1 = all zero except word 15 = 000001C0.
- w=0:
  - no `mem_re` at all;
  - single block = 80000000, zeros, word 15 = 0.
- Backpressure with w=20: `block_ready` low for 5 cycles, then high:
  - `block_data`/`block_last`/`block_idx` stable throughout the stall;
  - `start` pulses during `busy` are ignored.
- Reset mid-BUILD of block 1 with w=20:
  - all outputs go to 0 and no `done` pulse occurs;
  - a new `start` after reset produces a correct block 0 from scratch.
